// File: rtl/imem_loader.sv
// Boot loader: receives a counted, checksummed byte image and writes it into instruction memory,
// holding the core in reset until a load completes with a good checksum.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              start,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_CNT_LO = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_t              state_q;
    logic [7:0]          cnt_lo_q;
    logic [15:0]         cnt_q;
    logic [ADDR_W-1:0]   word_idx_q;
    logic [1:0]          byte_idx_q;
    logic [7:0]          sum_q;
    logic [23:0]         word_q;
    logic                we_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [31:0]         wdata_q;
    logic                rx_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                core_rst_n_q;

    logic                accept_s;
    logic [15:0]         n_full_s;
    logic                count_ok_s;
    logic                last_word_s;

    assign accept_s    = rx_valid && rx_ready_q;
    assign n_full_s    = {rx_data, cnt_lo_q};
    assign count_ok_s  = (n_full_s != 16'd0) && ({1'b0, n_full_s} <= MAX_WORDS);
    assign last_word_s = (17'(word_idx_q) == (17'(cnt_q) - 17'd1));

    // Loader FSM with all outputs registered alongside the state.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= ST_CNT_LO;
            cnt_lo_q     <= 8'd0;
            cnt_q        <= 16'd0;
            word_idx_q   <= '0;
            byte_idx_q   <= 2'd0;
            sum_q        <= 8'd0;
            word_q       <= 24'd0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= 32'd0;
            rx_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_CNT_LO: begin
                    if (accept_s) begin
                        cnt_lo_q <= rx_data;
                        state_q  <= ST_CNT_HI;
                    end
                end
                ST_CNT_HI: begin
                    if (accept_s) begin
                        cnt_q <= n_full_s;
                        if (count_ok_s) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q    <= ST_ERR;
                            err_q      <= 1'b1;
                            busy_q     <= 1'b0;
                            rx_ready_q <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        sum_q      <= sum_q + rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: word_q[7:0]   <= rx_data;
                            2'd1: word_q[15:8]  <= rx_data;
                            2'd2: word_q[23:16] <= rx_data;
                            2'd3: begin
                                we_q       <= 1'b1;
                                waddr_q    <= word_idx_q;
                                wdata_q    <= {rx_data, word_q};
                                word_idx_q <= word_idx_q + ADDR_W'(1);
                                if (last_word_s) begin
                                    state_q <= ST_CSUM;
                                end
                            end
                            default: byte_idx_q <= 2'd0;
                        endcase
                    end
                end
                ST_CSUM: begin
                    // start is not examined here, so a start coincident with this accept is dropped.
                    if (accept_s) begin
                        busy_q     <= 1'b0;
                        rx_ready_q <= 1'b0;
                        if (rx_data == sum_q) begin
                            state_q      <= ST_RUN;
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_RUN, ST_ERR: begin
                    if (start) begin
                        state_q      <= ST_CNT_LO;
                        core_rst_n_q <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                        rx_ready_q   <= 1'b1;
                        word_idx_q   <= '0;
                        byte_idx_q   <= 2'd0;
                        sum_q        <= 8'd0;
                    end
                end
                default: begin
                    state_q      <= ST_CNT_LO;
                    core_rst_n_q <= 1'b0;
                    busy_q       <= 1'b1;
                    done_q       <= 1'b0;
                    err_q        <= 1'b0;
                    rx_ready_q   <= 1'b1;
                    word_idx_q   <= '0;
                    byte_idx_q   <= 2'd0;
                    sum_q        <= 8'd0;
                end
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random images and gaps checked against a stream-level model.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    typedef logic [7:0] byte_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              start = 1'b0;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] fixed_words[2];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .start      (start),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the next word the model expects.
    always @(negedge CLK) begin
        if (we === 1'b1) begin
            if (exp_addr.size() == 0) begin
                check_eq("we_spurious", {31'd0, we}, 32'd0);
            end else begin
                check_eq("waddr", 32'(waddr), exp_addr.pop_front());
                check_eq("wdata", wdata, exp_data.pop_front());
            end
        end
        check_eq("core_rst_n_vs_done", {31'd0, core_rst_n}, {31'd0, done});
    end

    task automatic send_bytes(input byte_t q[$], input int gap_pct, input bit rand_start);
        bit ready_seen;
        int tries;
        foreach (q[i]) begin
            while ($urandom_range(99) < gap_pct) begin
                rx_valid = 1'b0;
                start    = rand_start && ($urandom_range(7) == 0);
                @(posedge CLK); #1;
            end
            rx_valid = 1'b1;
            rx_data  = q[i];
            start    = rand_start && ($urandom_range(7) == 0);
            tries    = 0;
            ready_seen = 1'b0;
            while (!ready_seen) begin
                @(negedge CLK);
                ready_seen = rx_ready;
                @(posedge CLK); #1;
                tries++;
                if (!ready_seen && tries > 50) begin
                    check_eq("rx_ready_wait", {31'd0, ready_seen}, 32'd1);
                    rx_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
            end
        end
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic check_idle_load_state(input string tag);
        check_eq({tag, "_busy"},       {31'd0, busy},       32'd1);
        check_eq({tag, "_done"},       {31'd0, done},       32'd0);
        check_eq({tag, "_err"},        {31'd0, err},        32'd0);
        check_eq({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
        check_eq({tag, "_rx_ready"},   {31'd0, rx_ready},   32'd1);
    endtask

    task automatic do_reset();
        RST = 1'b0; rx_valid = 1'b0; start = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check_idle_load_state("reset");
        check_eq("reset_we",    {31'd0, we},  32'd0);
        check_eq("reset_waddr", 32'(waddr),   32'd0);
        check_eq("reset_wdata", wdata,        32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        @(negedge CLK);
        check_idle_load_state("restart");
        @(posedge CLK); #1;
    endtask

    // Reference: a valid count yields N writes at 0..N-1; pass iff the checksum byte equals the data sum.
    task automatic load_image(input int n, input bit bad, input int gap_pct, input bit use_fixed);
        byte_t       bq[$];
        logic [31:0] w;
        logic [15:0] n16;
        logic [7:0]  s;
        bit          valid;
        bit          pass;
        n16   = n[15:0];
        valid = (n >= 1) && (n <= (1 << ADDR_W));
        s     = 8'd0;
        bq.push_back(n16[7:0]);
        bq.push_back(n16[15:8]);
        if (valid) begin
            for (int i = 0; i < n; i++) begin
                w = use_fixed ? fixed_words[i] : $urandom;
                exp_addr.push_back(32'(i));
                exp_data.push_back(w);
                for (int k = 0; k < 4; k++) begin
                    bq.push_back(w[8*k +: 8]);
                    s = s + w[8*k +: 8];
                end
            end
            bq.push_back(bad ? s + 8'd1 : s);
        end
        pass = valid && !bad;
        send_bytes(bq, gap_pct, 1'b1);
        @(negedge CLK);
        check_eq("end_done",       {31'd0, done},       {31'd0, pass});
        check_eq("end_err",        {31'd0, err},        {31'd0, !pass});
        check_eq("end_core_rst_n", {31'd0, core_rst_n}, {31'd0, pass});
        check_eq("end_busy",       {31'd0, busy},       32'd0);
        check_eq("end_rx_ready",   {31'd0, rx_ready},   32'd0);
        check_eq("writes_missing", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        @(posedge CLK); #1;
    endtask

    initial begin
        byte_t part[$];
        fixed_words[0] = 32'h0050_0093;
        fixed_words[1] = 32'h0010_0113;

        do_reset();
        load_image(2, 1'b0, 0, 1'b1);
        pulse_start();
        load_image(2, 1'b1, 0, 1'b1);
        pulse_start();
        load_image(0, 1'b0, 0, 1'b0);
        pulse_start();
        load_image(257, 1'b0, 0, 1'b0);
        pulse_start();
        load_image(256, 1'b0, 30, 1'b0);

        // Abort a load after five data bytes: only word 0 reaches memory.
        pulse_start();
        part = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
        exp_addr.push_back(32'd0);
        exp_data.push_back(fixed_words[0]);
        send_bytes(part, 0, 1'b0);
        @(negedge CLK);
        check_eq("partial_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        @(posedge CLK); #1;
        check_eq("partial_writes", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        do_reset();
        load_image(2, 1'b0, 0, 1'b1);

        pulse_start();
        load_image(2, 1'b0, 10, 1'b1);

        for (int t = 0; t < 6; t++) begin
            pulse_start();
            load_image($urandom_range(24, 1), $urandom_range(1) == 1, 20, 1'b0);
        end
        pulse_start();
        load_image($urandom_range(65535, 257), 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
